// File: rtl/dcache_pkg.sv
// Shared types and geometry for the data-cache miss controller.
// Beat counts are derived from the line size and the read/write port widths.
package dcache_pkg;
   localparam int LINE_WORDS = 16;
   localparam int RBKSZ      = 4;
   localparam int WBKSZ      = 4;
   localparam int NUM_LINES  = 64;
   localparam int WB_BEATS   = LINE_WORDS / RBKSZ;
   localparam int RF_BEATS   = LINE_WORDS / WBKSZ;
   localparam int BEAT_W     = $clog2((WB_BEATS > RF_BEATS) ? WB_BEATS : RF_BEATS) + 1;

   typedef logic [$clog2(NUM_LINES)-1:0]  laddr_t;
   typedef logic [$clog2(LINE_WORDS)-1:0] waddr_t;
   typedef logic [31:0]                   word_t;
   typedef logic [BEAT_W-1:0]             beat_t;

   typedef enum logic [2:0] {
      IDLE, WB_RD, WB_SEND, RF_REQ, RF_DATA, FIN
   } dcache_ctrl_state_t;
endpackage

// File: rtl/dcache_ctrl.sv
// Miss FSM: optional victim writeback, then line refill; clean miss = accept, RF_REQ, RF_BEATS beats, done.
// Memory requests are held stable until mem_req_ready; misses and stores are only accepted in IDLE.
module dcache_ctrl
   import dcache_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    miss_valid,
   output logic                    miss_ready,
   input  logic                    miss_dirty,
   input  laddr_t                  miss_laddr,
   input  logic [31:0]             miss_paddr,
   input  logic [31:0]             victim_paddr,
   output logic                    done,
   input  logic                    st_valid,
   output logic                    st_ready,
   input  laddr_t                  st_laddr,
   input  waddr_t                  st_waddr,
   input  word_t [WBKSZ-1:0]       st_data,
   output laddr_t                  c_laddra,
   output waddr_t                  c_waddra,
   output logic                    c_re,
   input  word_t [RBKSZ-1:0]       c_dout,
   output laddr_t                  c_laddrb,
   output waddr_t                  c_waddrb,
   output word_t [WBKSZ-1:0]       c_din,
   output logic                    c_we,
   output logic                    mem_req_valid,
   input  logic                    mem_req_ready,
   output logic                    mem_req_we,
   output logic [31:0]             mem_req_addr,
   output word_t [RBKSZ-1:0]       mem_wdata,
   input  logic                    mem_rvalid,
   input  word_t [WBKSZ-1:0]       mem_rdata
);
   dcache_ctrl_state_t r_state, w_next;
   beat_t              r_beat, w_beat_nxt;
   laddr_t             r_laddr;
   logic [31:0]        r_paddr, r_vpaddr;
   logic               r_dirty;
   logic               r_cap;
   word_t [RBKSZ-1:0]  r_wdata;
   logic [31:0]        w_wb_off;
   waddr_t             w_rd_waddr, w_rf_waddr;
   logic               w_wb_last, w_rf_last;

   assign w_wb_off   = 32'(r_beat) * 32'(RBKSZ * 4);
   assign w_rd_waddr = waddr_t'(32'(r_beat) * 32'(RBKSZ));
   assign w_rf_waddr = waddr_t'(32'(r_beat) * 32'(WBKSZ));
   assign w_wb_last  = (r_beat == beat_t'(WB_BEATS - 1));
   assign w_rf_last  = (r_beat == beat_t'(RF_BEATS - 1));
   // c_dout arrives in the first WB_SEND cycle; forward it then, replay the captured copy afterwards
   assign mem_wdata  = r_cap ? c_dout : r_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_beat   <= '0;
         r_laddr  <= '0;
         r_paddr  <= '0;
         r_vpaddr <= '0;
         r_dirty  <= 1'b0;
         r_cap    <= 1'b0;
         r_wdata  <= '0;
      end else begin
         r_state <= w_next;
         r_beat  <= w_beat_nxt;
         r_cap   <= (r_state == WB_RD);
         if (r_cap) r_wdata <= c_dout;
         if (r_state == IDLE && miss_valid) begin
            r_laddr  <= miss_laddr;
            r_paddr  <= miss_paddr;
            r_vpaddr <= victim_paddr;
            r_dirty  <= miss_dirty;
         end else if (r_state == WB_SEND && mem_req_ready && w_wb_last) begin
            r_dirty  <= 1'b0;
         end
      end
   end

   always_comb begin
      w_next        = r_state;
      w_beat_nxt    = r_beat;
      miss_ready    = 1'b0;
      st_ready      = 1'b0;
      done          = 1'b0;
      c_re          = 1'b0;
      c_laddra      = r_laddr;
      c_waddra      = w_rd_waddr;
      c_we          = 1'b0;
      c_laddrb      = r_laddr;
      c_waddrb      = w_rf_waddr;
      c_din         = mem_rdata;
      mem_req_valid = 1'b0;
      mem_req_we    = 1'b0;
      mem_req_addr  = r_paddr;
      case (r_state)
         IDLE: begin
            miss_ready = 1'b1;
            st_ready   = 1'b1;
            c_we       = st_valid;
            c_laddrb   = st_laddr;
            c_waddrb   = st_waddr;
            c_din      = st_data;
            if (miss_valid) w_next = miss_dirty ? WB_RD : RF_REQ;
         end
         WB_RD: begin
            c_re   = 1'b1;
            w_next = WB_SEND;
         end
         WB_SEND: begin
            mem_req_valid = 1'b1;
            mem_req_we    = r_dirty;
            mem_req_addr  = r_vpaddr + w_wb_off;
            if (mem_req_ready) begin
               if (w_wb_last) begin
                  w_beat_nxt = '0;
                  w_next     = RF_REQ;
               end else begin
                  w_beat_nxt = r_beat + beat_t'(1);
                  w_next     = WB_RD;
               end
            end
         end
         RF_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) w_next = RF_DATA;
         end
         RF_DATA: begin
            if (mem_rvalid) begin
               c_we = 1'b1;
               if (w_rf_last) begin
                  w_beat_nxt = '0;
                  w_next     = FIN;
               end else begin
                  w_beat_nxt = r_beat + beat_t'(1);
               end
            end
         end
         FIN: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 miss_valid/miss_ready  in/out  1/1  miss request handshake.
REQ-004 miss_dirty  in  1  victim line dirty; write back before refill.
REQ-005 miss_laddr  in  laddr_t  cache line index for victim and refill.
REQ-006 miss_paddr / victim_paddr  in  32/32  line-aligned byte addresses of refill and victim lines.
REQ-007 done  out  1  one-cycle pulse when a miss completes.
REQ-008 st_valid/st_ready  in/out  1/1  store write handshake.
REQ-009 st_laddr, st_waddr, st_data  in  laddr_t, waddr_t, word_t[WBKSZ-1:0]  store target and data.
REQ-010 c_laddra, c_waddra, c_re  out  laddr_t, waddr_t, 1  cache data read port.
REQ-011 c_dout  in  word_t[RBKSZ-1:0]  read data, valid one cycle after c_re.
REQ-012 c_laddrb, c_waddrb, c_din, c_we  out  laddr_t, waddr_t, word_t[WBKSZ-1:0], 1  cache data write port.
REQ-013 mem_req_valid/mem_req_ready  out/in  1/1  memory request handshake.
REQ-014 mem_req_we, mem_req_addr, mem_wdata  out  1, 32, word_t[RBKSZ-1:0]  request type, byte address, writeback beat.
REQ-015 mem_rvalid, mem_rdata  in  1, word_t[WBKSZ-1:0]  refill beat, no backpressure.

Function
REQ-016 FSM states: IDLE, WB_RD, WB_SEND, RF_REQ, RF_DATA, FIN.
REQ-017 IDLE: miss_ready=1, st_ready=1; all other controls low.
REQ-018 In IDLE, a store (st_valid=1) drives c_we=1 with c_laddrb=st_laddr, c_waddrb=st_waddr, c_din=st_data in the same cycle (combinational path).
REQ-019 A miss accepted in IDLE latches laddr, paddr, victim_paddr and dirty; next state is WB_RD if dirty, else RF_REQ.
REQ-020 A store and a miss in the same IDLE cycle are both accepted; the store write occurs in that cycle, before any writeback read.
REQ-021 Outside IDLE: miss_ready=0, st_ready=0, and c_we is driven only by refill.
REQ-022 WB_RD: c_re=1 for exactly one cycle, with c_laddra=latched laddr and c_waddra=beat*RBKSZ; then go to WB_SEND.
REQ-023 WB_SEND: capture c_dout into a register on entry; hold mem_req_valid=1, mem_req_we=1, addr=victim_paddr+beat*RBKSZ*4, and stable wdata until mem_req_ready.
REQ-024 On that handshake: beat+1; if the last of WB_BEATS, clear beat and go to RF_REQ, else go to WB_RD.
REQ-025 RF_REQ: hold mem_req_valid=1, mem_req_we=0, addr=miss_paddr until ready; then go to RF_DATA.
REQ-026 RF_DATA: each mem_rvalid writes mem_rdata via c_we=1, c_laddrb=laddr, c_waddrb=beat*WBKSZ, same cycle; after RF_BEATS beats go to FIN. mem_rvalid is ignored in all other states.
REQ-027 FIN: done=1 for one cycle, then IDLE. Minimum clean-miss latency is accept, RF_REQ handshake, RF_BEATS beats, then done.
REQ-028 Beat counter width is clog2(max(WB_BEATS,RF_BEATS))+1; no wrap occurs within a miss.

Reset
REQ-029 rst_n low forces, asynchronously: state=IDLE, beat=0, latched registers=0; mem_req_valid, c_re, c_we, done all low.
REQ-030 Reset mid-miss abandons the transaction without completion; the memory side is reset with the same rst_n.

Structure
REQ-031 dcache_pkg holds LINE_WORDS, WB_BEATS=LINE_WORDS/RBKSZ, RF_BEATS=LINE_WORDS/WBKSZ, and enum dcache_ctrl_state_t.
REQ-032 No sub-module; cache_mem_data is instantiated beside this block by the parent.

Verification (LINE_WORDS=16, RBKSZ=WBKSZ=4)
REQ-033 Clean miss, paddr 0x1000, laddr 5, ready immediate, 4 rvalid beats -> one mem read at 0x1000; c_we writes at waddrb 0,4,8,12 on laddr 5; done one cycle after the last beat.
REQ-034 Dirty miss, victim 0x2000 -> 4 read/write pairs to addrs 0x2000, 0x2010, 0x2020, 0x2030 with wdata equal to the line contents, then refill; no refill request before the 4th write.
REQ-035 mem_req_ready held low for 3 cycles mid-writeback -> addr and wdata stable throughout; no extra c_re.
REQ-036 Store and miss in the same IDLE cycle on the same laddr -> the store is written; the writeback beat contains the stored data.
REQ-037 st_valid during RF_DATA -> st_ready=0 and no store write until after done.
REQ-038 rst_n asserted during WB_SEND -> outputs low immediately; the next miss proceeds normally.
